// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: owns the fetch PC, issues one
// outstanding imem request at a time and hands fetched words to decode.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dec_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] inst_n, inst_pc_n;
  logic              valid_n;
  state_t            resume;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    inst_n    = inst;
    inst_pc_n = inst_pc;
    valid_n   = inst_valid;
    resume    = fetch_en ? S_REQ : S_IDLE;

    case (state)
      S_IDLE:  if (fetch_en) state_n = S_REQ;
      S_REQ:   state_n = S_WAIT;
      S_WAIT: begin
        if (imem_ack) begin
          inst_n    = imem_rdata;
          inst_pc_n = pc;
          valid_n   = 1'b1;
          pc_n      = pc + PC_STEP;
          state_n   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_valid && dec_ready) begin
          valid_n = 1'b0;
          state_n = resume;
        end
      end
      S_DRAIN: if (imem_ack) state_n = resume;
      default: state_n = S_IDLE;
    endcase

    // A redirect overrides everything above; a request already issued must be drained.
    if (redirect) begin
      pc_n      = redirect_pc;
      valid_n   = 1'b0;
      inst_n    = inst;
      inst_pc_n = inst_pc;
      case (state)
        S_IDLE, S_HOLD: state_n = resume;
        S_REQ:          state_n = S_DRAIN;
        S_WAIT:         state_n = imem_ack ? resume : S_DRAIN;
        S_DRAIN:        state_n = imem_ack ? resume : S_DRAIN;
        default:        state_n = S_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign busy      = (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - bench for fetch_sequencer: memory model, transaction-level
// fetch model, directed scenarios and randomized traffic.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_busy;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clock(clock), .reset(w_reset), .fetch_en(fetch_en),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .dec_ready(dec_ready),
    .redirect(1'b0), .redirect_pc(32'h0), .busy(w_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model state
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;
  int          lat_fixed;

  // Fetch model: expected next fetch address, outstanding request, words awaiting decode
  logic [31:0] exp_pc;
  bit          out_busy;
  bit          squashed;
  logic [31:0] out_addr;
  logic [31:0] mq[$];
  int          delivered;

  int          cyc;
  int          req_cyc[$];
  logic [31:0] req_addr[$];
  logic [31:0] acc_pc[$];

  always @(posedge clock)
    if (!reset && imem_ack)
      assert (busy && !imem_req) else $error("protocol: imem_ack outside WAIT/DRAIN");

  task automatic model_clear();
    mq.delete();
    out_busy  = 1'b0;
    squashed  = 1'b0;
    pend      = 1'b0;
    exp_pc    = 32'h0;
    imem_ack  = 1'b0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (pend) begin
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = pend_addr + 32'h100;
        pend       = 1'b0;
      end else cnt--;
    end

    check("inst_valid", inst_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      check("inst_pc", inst_pc, mq[0]);
      check("inst", inst, mq[0] + 32'h100);
    end
    check("busy", busy, out_busy || imem_req);
    if (imem_req) begin
      check("req_single_outstanding", out_busy, 1'b0);
      check("req_during_hold", (mq.size() != 0), 1'b0);
      check("imem_addr", imem_addr, exp_pc);
      req_cyc.push_back(cyc);
      req_addr.push_back(imem_addr);
    end

    if (mq.size() != 0 && dec_ready) begin
      if (!redirect) begin
        delivered++;
        acc_pc.push_back(mq[0]);
      end
      void'(mq.pop_front());
    end
    if (imem_ack) begin
      if (!squashed && !redirect) begin
        mq.push_back(out_addr);
        exp_pc = out_addr + 32'h1;
      end
      out_busy = 1'b0;
    end
    if (imem_req) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      out_busy  = 1'b1;
      out_addr  = exp_pc;
      squashed  = 1'b0;
    end
    if (redirect) begin
      exp_pc = redirect_pc;
      mq.delete();
      if (out_busy && !imem_ack) squashed = 1'b1;
    end

    @(posedge clock);
    @(negedge clock);
    redirect = 1'b0;
    cyc++;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 30 && !imem_req; i++) cycle();
    check({tag, "_req_seen"}, imem_req, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_req"}, imem_req, 1'b0);
    check({tag, "_inst_valid"}, inst_valid, 1'b0);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_inst_pc"}, inst_pc, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pc"}, imem_addr, 32'h0);
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1;
    fetch_en = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; w_ack = 1'b0; w_rdata = 32'h0;
    lat_fixed = 0; delivered = 0; cyc = 0;
    model_clear();
    repeat (2) @(negedge clock);
    check_reset_values("reset");

    // PC wrap on the instance that resets to the top of the address space
    w_reset = 1'b0;
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 5 && !w_req; i++) begin @(posedge clock); @(negedge clock); end
    check("wrap_req", w_req, 1'b1);
    check("wrap_addr", w_addr, 32'hFFFF_FFFF);
    @(posedge clock); @(negedge clock);
    w_ack = 1'b1; w_rdata = 32'h1234_5678;
    @(posedge clock); @(negedge clock);
    w_ack = 1'b0;
    check("wrap_valid", w_valid, 1'b1);
    check("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFF);
    check("wrap_inst", w_inst, 32'h1234_5678);
    @(posedge clock); @(negedge clock);
    check("wrap_next_req", w_req, 1'b1);
    check("wrap_next_addr", w_addr, 32'h0);
    w_reset = 1'b1;

    // Back-to-back fetch with 1-cycle ack: one instruction every 3 cycles
    reset = 1'b0;
    cyc = 0; req_cyc.delete(); req_addr.delete(); acc_pc.delete();
    repeat (12) cycle();
    check("tp_nreq", (req_cyc.size() >= 4), 1'b1);
    check("tp_nacc", (acc_pc.size() >= 3), 1'b1);
    for (int i = 0; i < 4 && i < req_cyc.size(); i++) begin
      check("tp_req_addr", req_addr[i], i);
      check("tp_req_cycle", req_cyc[i], 1 + 3 * i);
    end
    for (int i = 0; i < 3 && i < acc_pc.size(); i++) check("tp_acc_pc", acc_pc[i], i);

    // Decode stall in HOLD at pc 4
    for (int i = 0; i < 30 && !(inst_valid && inst_pc == 32'h4); i++) cycle();
    check("stall_reach", (inst_valid && inst_pc == 32'h4), 1'b1);
    dec_ready = 1'b0;
    repeat (5) begin
      check("stall_valid", inst_valid, 1'b1);
      check("stall_inst", inst, 32'h104);
      check("stall_no_req", imem_req, 1'b0);
      cycle();
    end
    dec_ready = 1'b1;
    check("stall_release_no_req", imem_req, 1'b0);
    cycle();
    check("stall_next_req", imem_req, 1'b1);
    check("stall_next_addr", imem_addr, 32'h5);

    // Redirect in WAIT, response 3 cycles later is drained
    lat_fixed = 3;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    check("drain_busy", busy, 1'b1);
    check("drain_no_req", imem_req, 1'b0);
    for (int i = 0; i < 10 && !imem_req; i++) begin
      check("drain_no_valid", inst_valid, 1'b0);
      cycle();
    end
    check("drain_next_addr", imem_addr, 32'h40);
    lat_fixed = 0;
    for (int i = 0; i < 10 && !inst_valid; i++) cycle();
    check("drain_deliver_pc", inst_pc, 32'h40);

    // Redirect coinciding with the ack in WAIT
    wait_req("ackredir");
    cycle();
    redirect = 1'b1; redirect_pc = 32'h80;
    cycle();
    check("ackredir_valid", inst_valid, 1'b0);
    check("ackredir_req", imem_req, 1'b1);
    check("ackredir_addr", imem_addr, 32'h80);

    // fetch_en dropped during WAIT
    cycle();
    fetch_en = 1'b0;
    cycle();
    check("fen_valid", inst_valid, 1'b1);
    check("fen_inst_pc", inst_pc, 32'h80);
    cycle();
    repeat (4) begin
      check("fen_idle_req", imem_req, 1'b0);
      check("fen_idle_busy", busy, 1'b0);
      cycle();
    end
    fetch_en = 1'b1;

    // Asynchronous reset in the middle of WAIT
    lat_fixed = 3;
    wait_req("areset");
    cycle();
    #2 reset = 1'b1;
    #1 check_reset_values("areset");
    model_clear();
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic
    lat_fixed = -1;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      fetch_en  = ($urandom_range(0, 9) != 0);
      dec_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 6) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      end
      cycle();
    end
    check("random_progress", (delivered > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
